// File: rtl/param_ring_pkg.sv
// Shared types and sizing helpers for the clocked parametrised ring chain.
package param_ring_pkg;

   typedef enum logic [1:0] {
      RING    = 2'd0,
      JOHNSON = 2'd1,
      HOLD    = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } fsm_e;

   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(2 * n);
   endfunction

   // HOLD never shifts, so its period only needs to be a harmless value.
   function automatic int unsigned period(input mode_e m, input int unsigned n);
      return (m == JOHNSON) ? 2 * n : n;
   endfunction

   // Both 2'b10 and 2'b11 select HOLD.
   function automatic mode_e decode_mode(input logic [1:0] m);
      mode_e r;
      case (m)
         2'b00:   r = RING;
         2'b01:   r = JOHNSON;
         default: r = HOLD;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ring_lap_counter.sv
// Position-within-lap counter with registered wrap pulse and modulo lap count.
module ring_lap_counter
   import param_ring_pkg::*;
#(
   parameter int unsigned N     = 100,
   parameter int unsigned LAP_W = 16,
   localparam int unsigned SW   = cnt_w(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_i,
   input  logic             clr_i,
   input  logic [SW:0]      period_i,
   output logic [SW-1:0]    step_count_o,
   output logic             at_last_c,
   output logic             wrap_o,
   output logic [LAP_W-1:0] lap_count_o
);

   logic [SW-1:0]    step_q, step_d;
   logic [LAP_W-1:0] lap_q, lap_d;
   logic             wrap_q, wrap_d;

   // ">=" keeps a stale position left by an immediate stop from running past the lap.
   assign at_last_c = ({1'b0, step_q} >= (period_i - (SW+1)'(1)));

   always_comb begin
      step_d = step_q;
      lap_d  = lap_q;
      wrap_d = 1'b0;
      if (clr_i) begin
         step_d = '0;
      end else if (shift_i) begin
         if (at_last_c) begin
            step_d = '0;
            wrap_d = 1'b1;
            lap_d  = lap_q + LAP_W'(1);
         end else begin
            step_d = step_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q <= '0;
         lap_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         step_q <= step_d;
         lap_q  <= lap_d;
         wrap_q <= wrap_d;
      end
   end

   assign step_count_o = step_q;
   assign lap_count_o  = lap_q;
   assign wrap_o       = wrap_q;

endmodule

// File: rtl/param_ring_chain.sv
// N-stage clocked ring/Johnson pattern generator with seed load, start/stop control
// and lap accounting.
module param_ring_chain
   import param_ring_pkg::*;
#(
   parameter int unsigned N            = 100,
   parameter int unsigned LAP_W        = 16,
   parameter bit          STOP_AT_WRAP = 1'b1,
   localparam int unsigned SW          = cnt_w(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load_valid,
   input  logic [N-1:0]     load_data,
   output logic             load_ready,
   output logic [N-1:0]     state_q,
   output logic [SW-1:0]    step_count,
   output logic             wrap,
   output logic [LAP_W-1:0] lap_count,
   output logic             busy
);

   fsm_e         fsm_q, fsm_d;
   mode_e        mode_q, mode_d;
   logic [N-1:0] ring_q, ring_d;
   logic         busy_q, load_ready_q;
   logic         shift_c, clr_c, at_last_c;
   logic [SW:0]  period_c;

   assign period_c = (SW+1)'(period(mode_q, N));

   // Next-state, shift strobe and ring update.
   always_comb begin
      fsm_d   = fsm_q;
      mode_d  = mode_q;
      ring_d  = ring_q;
      shift_c = 1'b0;
      clr_c   = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (load_valid) begin
               ring_d = load_data;
               clr_c  = 1'b1;
            end else if (en) begin
               mode_d = decode_mode(mode);
               fsm_d  = RUN;
            end
         end
         RUN: begin
            if (!en && (!STOP_AT_WRAP || (step_count == '0))) begin
               fsm_d = IDLE;
            end else begin
               shift_c = (mode_q != HOLD);
               if (!en) fsm_d = STOPPING;
            end
         end
         STOPPING: begin
            if (en) begin
               fsm_d   = RUN;
               shift_c = (mode_q != HOLD);
            end else if (mode_q == HOLD) begin
               fsm_d = IDLE;
            end else begin
               shift_c = 1'b1;
               if (at_last_c) fsm_d = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
      if (shift_c)
         ring_d = {ring_q[N-2:0], (mode_q == JOHNSON) ? ~ring_q[N-1] : ring_q[N-1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q        <= IDLE;
         mode_q       <= RING;
         ring_q       <= '0;
         busy_q       <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         fsm_q        <= fsm_d;
         mode_q       <= mode_d;
         ring_q       <= ring_d;
         busy_q       <= (fsm_d != IDLE);
         load_ready_q <= (fsm_d == IDLE);
      end
   end

   ring_lap_counter #(
      .N     (N),
      .LAP_W (LAP_W)
   ) u_lap (
      .clk          (clk),
      .rst_n        (rst_n),
      .shift_i      (shift_c),
      .clr_i        (clr_c),
      .period_i     (period_c),
      .step_count_o (step_count),
      .at_last_c    (at_last_c),
      .wrap_o       (wrap),
      .lap_count_o  (lap_count)
   );

   assign state_q    = ring_q;
   assign busy       = busy_q;
   assign load_ready = load_ready_q;

endmodule

// File: tb/tb_param_ring_chain.sv
// Directed bench: three instances (graceful stop, immediate stop, tiny lap counter)
// share the control inputs so each scenario checks them side by side.
module tb_param_ring_chain;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        load_valid = 1'b0;
   logic [3:0]  load_data = 4'b0000;
   logic [1:0]  ld_small = 2'b00;

   logic [3:0]  s_state, i_state;
   logic [2:0]  s_step, i_step;
   logic [15:0] s_lap, i_lap;
   logic        s_wrap, s_ready, s_busy, i_wrap, i_ready, i_busy;
   logic [1:0]  m_state, m_step, m_lap;
   logic        m_wrap, m_ready, m_busy;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   param_ring_chain #(.N(4), .LAP_W(16), .STOP_AT_WRAP(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load_valid(load_valid),
      .load_data(load_data), .load_ready(s_ready), .state_q(s_state),
      .step_count(s_step), .wrap(s_wrap), .lap_count(s_lap), .busy(s_busy));

   param_ring_chain #(.N(4), .LAP_W(16), .STOP_AT_WRAP(1'b0)) dut_imm (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load_valid(load_valid),
      .load_data(load_data), .load_ready(i_ready), .state_q(i_state),
      .step_count(i_step), .wrap(i_wrap), .lap_count(i_lap), .busy(i_busy));

   param_ring_chain #(.N(2), .LAP_W(2), .STOP_AT_WRAP(1'b1)) dut_small (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load_valid(load_valid),
      .load_data(ld_small), .load_ready(m_ready), .state_q(m_state),
      .step_count(m_step), .wrap(m_wrap), .lap_count(m_lap), .busy(m_busy));

   task automatic do_reset();
      @(negedge clk);
      en = 1'b0; load_valid = 1'b0; mode = 2'b00; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      @(negedge clk);
      n_total++; if (s_state !== 4'b0000) $display("FAIL reset_state: got %b want 0000", s_state); else n_pass++;
      n_total++; if (s_step !== 3'd0) $display("FAIL reset_step: got %0d want 0", s_step); else n_pass++;
      n_total++; if (s_lap !== 16'd0 || i_lap !== 16'd0 || m_lap !== 2'd0) $display("FAIL reset_lap: got %0d/%0d/%0d want 0", s_lap, i_lap, m_lap); else n_pass++;
      n_total++; if (s_wrap !== 1'b0 || i_wrap !== 1'b0 || m_wrap !== 1'b0) $display("FAIL reset_wrap: got %b%b%b want 000", s_wrap, i_wrap, m_wrap); else n_pass++;
      n_total++; if (s_ready !== 1'b1 || m_ready !== 1'b1) $display("FAIL reset_ready: got %b%b want 11", s_ready, m_ready); else n_pass++;
      n_total++; if (s_busy !== 1'b0 || m_busy !== 1'b0) $display("FAIL reset_busy: got %b%b want 00", s_busy, m_busy); else n_pass++;
      n_total++; if (m_step !== 2'd0 || m_state !== 2'b00) $display("FAIL reset_small: got step %0d state %b want 0 00", m_step, m_state); else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_johnson();
      logic [3:0] exp_seq [8];
      exp_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
      do_reset();
      mode = 2'b01; en = 1'b1;
      @(negedge clk);
      n_total++; if (s_state !== 4'b0000 || s_busy !== 1'b1) $display("FAIL johnson_start: got state %b busy %b want 0000 1", s_state, s_busy); else n_pass++;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_total++; if (s_state !== exp_seq[k]) $display("FAIL johnson_shift%0d: got %b want %b", k, s_state, exp_seq[k]); else n_pass++;
         n_total++; if (s_wrap !== (k == 7)) $display("FAIL johnson_wrap%0d: got %b want %b", k, s_wrap, (k == 7)); else n_pass++;
      end
      n_total++; if (s_lap !== 16'd1 || s_step !== 3'd0) $display("FAIL johnson_lap: got lap %0d step %0d want 1 0", s_lap, s_step); else n_pass++;
      en = 1'b0;
      @(negedge clk);
      n_total++; if (s_busy !== 1'b0 || s_state !== 4'b0000) $display("FAIL johnson_stop_at_zero: got busy %b state %b want 0 0000", s_busy, s_state); else n_pass++;
   endtask

   task automatic test_ring();
      logic [3:0] exp_seq [4];
      exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      mode = 2'b00; load_valid = 1'b1; load_data = 4'b0001; ld_small = 2'b01;
      @(negedge clk);
      load_valid = 1'b0;
      n_total++; if (s_state !== 4'b0001 || m_state !== 2'b01) $display("FAIL ring_load: got %b/%b want 0001/01", s_state, m_state); else n_pass++;
      en = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_total++; if (s_state !== exp_seq[k % 4]) $display("FAIL ring_shift%0d: got %b want %b", k, s_state, exp_seq[k % 4]); else n_pass++;
         n_total++; if (s_wrap !== ((k % 4) == 3)) $display("FAIL ring_wrap%0d: got %b want %b", k, s_wrap, ((k % 4) == 3)); else n_pass++;
         if (k == 5) begin
            n_total++; if (m_lap !== 2'd3) $display("FAIL small_lap3: got %0d want 3", m_lap); else n_pass++;
         end
      end
      n_total++; if (s_lap !== 16'd2) $display("FAIL ring_lap2: got %0d want 2", s_lap); else n_pass++;
      n_total++; if (m_lap !== 2'd0 || m_wrap !== 1'b1) $display("FAIL small_lap_rollover: got lap %0d wrap %b want 0 1", m_lap, m_wrap); else n_pass++;
      en = 1'b0;
   endtask

   task automatic test_stop();
      do_reset();
      mode = 2'b01; en = 1'b1;
      @(negedge clk);
      repeat (3) @(negedge clk);
      n_total++; if (s_state !== 4'b0111 || i_state !== 4'b0111) $display("FAIL stop_pre: got %b/%b want 0111", s_state, i_state); else n_pass++;
      en = 1'b0;
      @(negedge clk);
      n_total++; if (i_busy !== 1'b0 || i_ready !== 1'b1) $display("FAIL imm_idle: got busy %b ready %b want 0 1", i_busy, i_ready); else n_pass++;
      n_total++; if (i_state !== 4'b0111 || i_step !== 3'd3) $display("FAIL imm_held: got state %b step %0d want 0111 3", i_state, i_step); else n_pass++;
      n_total++; if (s_busy !== 1'b1 || s_state !== 4'b1111) $display("FAIL grace_first: got busy %b state %b want 1 1111", s_busy, s_state); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_total++; if (s_busy !== (k < 3)) $display("FAIL grace_busy%0d: got %b want %b", k, s_busy, (k < 3)); else n_pass++;
      end
      n_total++; if (s_state !== 4'b0000 || s_lap !== 16'd1) $display("FAIL grace_end: got state %b lap %0d want 0000 1", s_state, s_lap); else n_pass++;
      n_total++; if (s_ready !== 1'b1 || s_wrap !== 1'b1) $display("FAIL grace_ready_wrap: got ready %b wrap %b want 1 1", s_ready, s_wrap); else n_pass++;
      n_total++; if (i_state !== 4'b0111) $display("FAIL imm_still_held: got %b want 0111", i_state); else n_pass++;
   endtask

   task automatic test_handshake();
      do_reset();
      mode = 2'b00; load_valid = 1'b1; load_data = 4'b0001;
      @(negedge clk);
      load_valid = 1'b0; en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_total++; if (s_state !== 4'b0010) $display("FAIL hs_run_shift: got %b want 0010", s_state); else n_pass++;
      load_valid = 1'b1; load_data = 4'b1111;
      @(negedge clk);
      n_total++; if (s_state !== 4'b0100 || s_ready !== 1'b0) $display("FAIL hs_load_in_run: got state %b ready %b want 0100 0", s_state, s_ready); else n_pass++;
      n_total++; if (s_step !== 3'd2) $display("FAIL hs_step: got %0d want 2", s_step); else n_pass++;
      do_reset();
      load_valid = 1'b1; load_data = 4'b1010; en = 1'b1;
      @(negedge clk);
      n_total++; if (s_state !== 4'b1010 || s_busy !== 1'b0 || s_ready !== 1'b1) $display("FAIL hs_priority: got state %b busy %b ready %b want 1010 0 1", s_state, s_busy, s_ready); else n_pass++;
      @(negedge clk);
      n_total++; if (s_busy !== 1'b0) $display("FAIL hs_priority_hold: got busy %b want 0", s_busy); else n_pass++;
      load_valid = 1'b0;
      @(negedge clk);
      n_total++; if (s_busy !== 1'b1 || s_state !== 4'b1010) $display("FAIL hs_start_no_shift: got busy %b state %b want 1 1010", s_busy, s_state); else n_pass++;
      en = 1'b0;
   endtask

   task automatic test_reset_midrun();
      do_reset();
      mode = 2'b01; en = 1'b1;
      @(negedge clk);
      repeat (11) @(negedge clk);
      n_total++; if (s_state !== 4'b0111 || s_step !== 3'd3 || s_lap !== 16'd1) $display("FAIL midrun_pre: got state %b step %0d lap %0d want 0111 3 1", s_state, s_step, s_lap); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++; if (s_state !== 4'b0000 || s_step !== 3'd0 || s_lap !== 16'd0) $display("FAIL midrun_async: got state %b step %0d lap %0d want 0000 0 0", s_state, s_step, s_lap); else n_pass++;
      n_total++; if (s_busy !== 1'b0 || s_ready !== 1'b1 || s_wrap !== 1'b0) $display("FAIL midrun_flags: got busy %b ready %b wrap %b want 0 1 0", s_busy, s_ready, s_wrap); else n_pass++;
      repeat (2) @(negedge clk);
      n_total++; if (s_wrap !== 1'b0 || s_state !== 4'b0000) $display("FAIL midrun_no_wrap: got wrap %b state %b want 0 0000", s_wrap, s_state); else n_pass++;
      en = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_johnson();
      test_ring();
      test_stop();
      test_handshake();
      test_reset_midrun();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/param_ring_chain.md
Name: param_ring_chain

Overview:
- Clocked, parametrised successor to the free-running inverter/buffer ring oscillator.
- N-stage register ring with a selectable loop mode:
  - RING: straight feedback, period N.
  - JOHNSON: inverted feedback, period 2N.
  - HOLD: no shift.
- Adds seed loading over a valid/ready handshake, controlled start/stop with optional stop-at-lap-boundary, a step counter, a wrap pulse and a lap counter.
- Serves as a deterministic pattern/phase generator and as a clocked reference model for the asynchronous ring examples.

Parameters:
- N, 100, number of ring stages; legal range N >= 2.
- LAP_W, 16, width of the lap counter.
- STOP_AT_WRAP, 1, 1 = stop completes only at a lap boundary; 0 = stop takes effect immediately.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run request (level).
- mode  in  2  00 RING, 01 JOHNSON, 10/11 HOLD; sampled only in IDLE.
- load_valid  in  1  seed load request.
- load_data  in  N  seed value.
- load_ready  out  1  high only in IDLE.
- state_q  out  N  ring contents; bit i = stage i.
- step_count  out  SW  position within the lap; SW = clog2(2N).
- wrap  out  1  one-cycle pulse on lap completion.
- lap_count  out  LAP_W  completed laps, modulo 2^LAP_W.
- busy  out  1  high in RUN or STOPPING.

Behaviour:
- Reset (asynchronous, any state) values:
  - state_q = 0, step_count = 0, lap_count = 0, wrap = 0.
  - FSM = IDLE, so load_ready = 1 and busy = 0.
  - Latched mode = RING.
- Shift rules, applied in RUN and STOPPING:
  - Bit i <= bit i-1 for i >= 1.
  - RING: bit0 <= bit N-1.
  - JOHNSON: bit0 <= ~bit N-1.
  - HOLD: no shift; step_count frozen.
- Period P: N for RING, 2N for JOHNSON.
- Step counter:
  - step_count increments on each shift.
  - When step_count = P-1 and a shift occurs, it returns to 0, wrap = 1 on the next cycle and lap_count increments (modulo, no saturation).
- FSM IDLE:
  - load_valid = 1 loads state_q <= load_data and step_count <= 0; lap_count is unchanged.
  - en = 1 with load_valid = 0 latches mode and moves to RUN. No shift occurs in the transition cycle; the first shift is on the following edge.
  - If load_valid and en are both high, the load wins and the FSM stays in IDLE.
- FSM RUN:
  - Shifts every cycle.
  - On en = 0 with STOP_AT_WRAP = 0, or with step_count = 0: go to IDLE with no shift on that edge.
  - Otherwise on en = 0: go to STOPPING.
- FSM STOPPING:
  - Keeps shifting.
  - On the shift that takes step_count from P-1 to 0, go to IDLE. wrap still pulses and the lap is counted.
  - en = 1 returns to RUN with no lost shift.
  - In HOLD mode, STOPPING exits to IDLE immediately.
- Handshakes and mode:
  - load_valid outside IDLE is ignored; load_ready = 0 there.
  - mode changes outside IDLE have no effect until the next IDLE -> RUN.
- Reset mid-run aborts at once; there is no lap completion and no wrap.
- All outputs are registered.

Decomposition:
- Package param_ring_pkg:
  - mode_e {RING, JOHNSON, HOLD}.
  - fsm_e {IDLE, RUN, STOPPING}.
  - Function period(mode, N).
  - Function cnt_w(N) = clog2(2N).
- Sub-module ring_lap_counter: step_count, wrap detection and the lap_count register. Inputs are shift strobe and period; outputs are step_count, at_last and wrap.
- Top level holds the FSM, the shift register and the load handshake.

Test Plan:
- Reset, N=4, JOHNSON:
  - Stimulus: en = 1 from state 0000.
  - Required: state_q steps 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
  - Required: wrap pulses after the 8th shift, lap_count = 1, step_count = 0.
- N=4, RING:
  - Stimulus: load 0001 in IDLE, then en = 1.
  - Required: state_q steps 0010, 0100, 1000, 0001; wrap after the 4th shift; 8 shifts give lap_count = 2.
- Graceful stop, N=4, JOHNSON, STOP_AT_WRAP = 1:
  - Stimulus: drop en after 3 shifts (state 0111).
  - Required: busy stays high for 5 more shifts, then IDLE with state 0000, lap_count = 1, load_ready = 1.
- Immediate stop, STOP_AT_WRAP = 0:
  - Stimulus: same as the graceful-stop scenario.
  - Required: IDLE on the next edge, state 0111 held, step_count = 3.
- Handshake priority:
  - Stimulus: load_valid during RUN.
  - Required: ignored, load_ready = 0, state unaffected.
  - Stimulus: load_valid and en together in IDLE.
  - Required: load taken, FSM stays IDLE.
- Reset and counter wrap:
  - Stimulus: assert rst_n low mid-lap.
  - Required: all outputs zero asynchronously, no wrap pulse.
  - Stimulus: LAP_W = 2, N = 2, RING, run 4 laps.
  - Required: lap_count returns to 0.
